// File: rtl/bsg_manycore_host_req_gate.sv
// bsg_manycore_host_req_gate
//
// Credit-gated host request buffer sitting between the DPI host-request
// source and the manycore endpoint's host request input. Host packets are
// held in a small circular FIFO and released to the endpoint only while the
// endpoint advertises an out-credit. Because the endpoint's credit counter
// lags a dequeue by one cycle, the credit consumed by the most recent issue
// is subtracted locally (issued_r) before deciding whether to issue again.
// A fence drains the FIFO, waits for every credit to return, then pulses
// fence_done_o.
//
// Optional feature macro: HOST_REQ_GATE_STALL_STATS_EN
//   defined   -> stall_cycles_o counts cycles where a request is buffered but
//                no credit is available (32-bit, saturating, reset-cleared)
//   undefined -> stall_cycles_o is tied to 0
//
// Ports:
//   clk_i             clock
//   reset_n_i         asynchronous active-low reset
//   host_req_i        request packet from the host
//   host_req_v_i      host request valid
//   host_req_ready_o  buffer can accept a request
//   ep_req_o          FIFO head presented to the endpoint
//   ep_req_v_o        request valid to the endpoint
//   ep_req_ready_i    endpoint accepts the request
//   ep_out_credits_i  endpoint's advertised out-credits
//   fence_i           fence request (level, sampled on clk_i)
//   fence_done_o      one-cycle fence completion pulse
//   fence_busy_o      high while a fence is in progress
//   occupancy_o       number of buffered entries
//   stall_cycles_o    credit-stall cycle counter

module bsg_manycore_host_req_gate #(
  parameter int fifo_width_p      = 32,
  parameter int max_out_credits_p = 4,
  parameter int els_p             = 4,
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
  localparam int occ_width_lp     = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [fifo_width_p-1:0]    host_req_i,
  input  logic                       host_req_v_i,
  output logic                       host_req_ready_o,
  output logic [fifo_width_p-1:0]    ep_req_o,
  output logic                       ep_req_v_o,
  input  logic                       ep_req_ready_i,
  input  logic [credit_width_lp-1:0] ep_out_credits_i,
  input  logic                       fence_i,
  output logic                       fence_done_o,
  output logic                       fence_busy_o,
  output logic [occ_width_lp-1:0]    occupancy_o,
  output logic [31:0]                stall_cycles_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam logic [occ_width_lp-1:0]    full_count_lp  = occ_width_lp'(els_p);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                    state_r, state_n_s;
  logic [fifo_width_p-1:0]   mem_r [els_p];
  logic [ptr_width_lp-1:0]   rptr_r, wptr_r;
  logic [occ_width_lp-1:0]   count_r;
  logic                      issued_r;
  logic [credit_width_lp:0]  avail_s;
  logic                      avail_nz_s;
  logic                      enq_s, deq_s;
  logic                      empty_s, full_s;
  logic                      drain_done_s;

  assign empty_s = (count_r == {occ_width_lp{1'b0}});
  assign full_s  = (count_r == full_count_lp);

  // Credits still usable this cycle: advertised credits minus the one taken
  // by last cycle's issue (not yet visible in the endpoint's counter),
  // clamped at zero.
  always_comb begin
    avail_s = {(credit_width_lp+1){1'b0}};
    if ({1'b0, ep_out_credits_i} > {{credit_width_lp{1'b0}}, issued_r}) begin
      avail_s = {1'b0, ep_out_credits_i} - {{credit_width_lp{1'b0}}, issued_r};
    end else begin
      avail_s = {(credit_width_lp+1){1'b0}};
    end
  end

  assign avail_nz_s = (avail_s != {(credit_width_lp+1){1'b0}});

  // ep_req_v_o is a function of buffer state and credits only; ready from
  // the endpoint never feeds back into it.
  assign ep_req_v_o = !empty_s && avail_nz_s;
  assign ep_req_o   = mem_r[rptr_r];

  // The reset term keeps ready low while reset is asserted.
  assign host_req_ready_o = reset_n_i && !full_s && (state_r == RUN);

  assign enq_s = host_req_v_i && host_req_ready_o;
  assign deq_s = ep_req_v_o && ep_req_ready_i;

  assign occupancy_o  = count_r;
  assign fence_done_o = (state_r == DONE);
  assign fence_busy_o = (state_r != RUN);

  assign drain_done_s = empty_s && !issued_r && (ep_out_credits_i == max_credits_lp);

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wptr_r] <= host_req_i;
    end
  end

  // Pointers, count and the one-cycle issued flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r   <= {ptr_width_lp{1'b0}};
      wptr_r   <= {ptr_width_lp{1'b0}};
      count_r  <= {occ_width_lp{1'b0}};
      issued_r <= 1'b0;
    end else begin
      issued_r <= deq_s;
      if (enq_s) begin
        wptr_r <= wptr_r + {{(ptr_width_lp-1){1'b0}}, 1'b1};
      end
      if (deq_s) begin
        rptr_r <= rptr_r + {{(ptr_width_lp-1){1'b0}}, 1'b1};
      end
      if (enq_s && !deq_s) begin
        count_r <= count_r + {{(occ_width_lp-1){1'b0}}, 1'b1};
      end else if (!enq_s && deq_s) begin
        count_r <= count_r - {{(occ_width_lp-1){1'b0}}, 1'b1};
      end
    end
  end

  // Fence state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= RUN;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Fence next-state logic; DONE always returns to RUN so a still-high
  // fence_i starts a fresh fence from RUN.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      RUN: begin
        if (fence_i) begin
          state_n_s = DRAIN;
        end else begin
          state_n_s = RUN;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = DRAIN;
        end
      end
      DONE:    state_n_s = RUN;
      default: state_n_s = RUN;
    endcase
  end

`ifdef HOST_REQ_GATE_STALL_STATS_EN
  logic [31:0] stall_cnt_r;
  logic        stall_s;

  assign stall_s = !empty_s && !avail_nz_s;

  // Saturating count of cycles where work is buffered but credit-blocked.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_r;
`else
  assign stall_cycles_o = 32'd0;
`endif

  // Credits above the endpoint maximum are out of contract.
  always @(posedge clk_i) begin
    assert (!reset_n_i || (ep_out_credits_i <= max_credits_lp))
      else $error("ep_out_credits_i %0d exceeds max_out_credits_p", ep_out_credits_i);
  end

endmodule
